// File: rtl/mem_transmitter.sv
// Store-path aligner: turns one SB/SH/SW request into one or two word-aligned byte-enabled write beats.
// Optional feature macro: MEM_TX_SPLIT_EN (defined = split word-crossing stores into two beats).
module mem_transmitter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [2:0]        req_func3,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              store_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [1:0] off;
  logic [3:0] mask;
  logic [7:0] wide_be;
  logic       legal;
  logic       crossing;
  logic       reject;
  logic       accept;

`ifdef MEM_TX_SPLIT_EN
  logic [63:0] wide_data;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_be_q, hi_be_d;
  logic        cross_q, cross_d;
`else
  logic [31:0] wide_data;
`endif

  assign off       = req_addr[1:0];
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign store_err = (state_q == ERR);
  assign mem_valid = (state_q == BEAT0) || (state_q == BEAT1);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign accept    = req_valid & req_ready;

  always_comb begin
    mask  = 4'b0000;
    legal = 1'b1;
    case (req_func3)
      3'b000:  mask = 4'b0001;
      3'b001:  mask = 4'b0011;
      3'b010:  mask = 4'b1111;
      default: legal = 1'b0;
    endcase
  end

`ifdef MEM_TX_SPLIT_EN
  assign wide_data = {32'b0, req_data} << {off, 3'b000};
`else
  assign wide_data = req_data << {off, 3'b000};
`endif
  assign wide_be  = {4'b0000, mask} << off;
  assign crossing = (wide_be[7:4] != 4'b0000);
`ifdef MEM_TX_SPLIT_EN
  assign reject   = !legal;
`else
  assign reject   = !legal || crossing;
`endif

  // Beat registers are zero whenever no beat is offered, and hold while the memory stalls.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef MEM_TX_SPLIT_EN
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
    cross_d   = cross_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            state_d = ERR;
          end else begin
            state_d = BEAT0;
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = wide_data[31:0];
            be_d    = wide_be[3:0];
`ifdef MEM_TX_SPLIT_EN
            hi_data_d = wide_data[63:32];
            hi_be_d   = wide_be[7:4];
            cross_d   = crossing;
`endif
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
`ifdef MEM_TX_SPLIT_EN
          if (cross_q) begin
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = hi_data_q;
            be_d    = hi_be_q;
          end
`endif
        end
      end
`ifdef MEM_TX_SPLIT_EN
      BEAT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifdef MEM_TX_SPLIT_EN
      hi_data_q <= '0;
      hi_be_q   <= '0;
      cross_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
`ifdef MEM_TX_SPLIT_EN
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
      cross_q   <= cross_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_transmitter.sv
// Directed self-checking bench for mem_transmitter; follows MEM_TX_SPLIT_EN to pick split or reject expectations.
module tb_mem_transmitter;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_func3;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        store_err;

  int checkCount = 0;
  int errorCount = 0;

  mem_transmitter #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_func3 (req_func3),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .store_err (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for req_ready, and returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] func3);
    int waitCycles;
    req_addr  = addr;
    req_data  = data;
    req_func3 = func3;
    req_valid = 1'b1;
    waitCycles = 0;
    while (!req_ready && waitCycles < 20) begin
      nextCycle();
      waitCycles++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
    nextCycle();
    req_valid = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    checkOutput({tag, "_valid"}, 64'(mem_valid), 64'd1);
    checkOutput({tag, "_addr"},  64'(mem_addr),  64'(addr));
    checkOutput({tag, "_be"},    64'(mem_be),    64'(be));
    checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 64'(mem_valid), 64'd0);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, "_be"},    64'(mem_be),    64'd0);
    checkOutput({tag, "_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_func3 = '0;
    mem_ready = 1'b1;
    #1;
    checkIdle("reset");
    checkOutput("reset_err",   64'(store_err), 64'd0);
    checkOutput("reset_addr",  64'(mem_addr),  64'd0);
    checkOutput("reset_wdata", 64'(mem_wdata), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    // SB at offset 3
    applyStimulus(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
    checkBeat("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    checkOutput("sb_busy",  64'(busy),      64'd1);
    checkOutput("sb_ready", 64'(req_ready), 64'd0);
    nextCycle();
    checkIdle("sb_done");

    // SH at offset 2 with three stall cycles
    mem_ready = 1'b0;
    applyStimulus(32'h0000_2002, 32'h0000_1234, 3'b001);
    for (int i = 0; i < 4; i++) begin
      checkBeat($sformatf("sh_hold%0d", i), 32'h0000_2000, 4'b1100, 32'h1234_0000);
      checkOutput($sformatf("sh_hold%0d_ready", i), 64'(req_ready), 64'd0);
      if (i == 3) mem_ready = 1'b1;
      nextCycle();
    end
    checkIdle("sh_done");

    // SH at offset 1 does not cross and stays a single beat
    applyStimulus(32'h0000_4001, 32'h0000_BEEF, 3'b001);
    checkBeat("sh1", 32'h0000_4000, 4'b0110, 32'h00BE_EF00);
    nextCycle();
    checkIdle("sh1_done");

    // SW at offset 1 crosses a word boundary
    applyStimulus(32'h0000_3001, 32'h1122_3344, 3'b010);
`ifdef MEM_TX_SPLIT_EN
    checkBeat("sw_b0", 32'h0000_3000, 4'b1110, 32'h2233_4400);
    nextCycle();
    checkBeat("sw_b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
    nextCycle();
    checkIdle("sw_done");
`else
    checkOutput("sw_err",   64'(store_err), 64'd1);
    checkOutput("sw_valid", 64'(mem_valid), 64'd0);
    nextCycle();
    checkOutput("sw_err_clr", 64'(store_err), 64'd0);
    checkIdle("sw_done");
`endif

    // SW at top of address space wraps beat 1 to zero
    applyStimulus(32'hFFFF_FFFE, 32'hA1B2_C3D4, 3'b010);
`ifdef MEM_TX_SPLIT_EN
    checkBeat("wrap_b0", 32'hFFFF_FFFC, 4'b1100, 32'hC3D4_0000);
    nextCycle();
    checkBeat("wrap_b1", 32'h0000_0000, 4'b0011, 32'h0000_A1B2);
    nextCycle();
    checkIdle("wrap_done");
`else
    checkOutput("wrap_err",   64'(store_err), 64'd1);
    checkOutput("wrap_valid", 64'(mem_valid), 64'd0);
    nextCycle();
    checkIdle("wrap_done");
`endif

    // Illegal func3
    applyStimulus(32'h0000_5000, 32'h1234_5678, 3'b011);
    checkOutput("ill_err",   64'(store_err), 64'd1);
    checkOutput("ill_valid", 64'(mem_valid), 64'd0);
    checkOutput("ill_ready", 64'(req_ready), 64'd0);
    nextCycle();
    checkOutput("ill_err_clr", 64'(store_err), 64'd0);
    checkIdle("ill_done");

    // Asynchronous reset in the middle of a store
`ifdef MEM_TX_SPLIT_EN
    applyStimulus(32'h0000_3001, 32'h1122_3344, 3'b010);
    nextCycle();
    mem_ready = 1'b0;
    checkBeat("rst_b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
`else
    mem_ready = 1'b0;
    applyStimulus(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
    checkBeat("rst_b0", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("rst_mid");
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    nextCycle();
    checkIdle("rst_after");
    applyStimulus(32'h0000_0005, 32'h0000_0077, 3'b000);
    checkBeat("post_rst", 32'h0000_0004, 4'b0010, 32'h0000_7700);
    nextCycle();
    checkIdle("post_rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
